// File: rtl/cam_pkg.sv
// Shared types and encodings for the CAM sequencing controller.
// Optional feature macro used by this slice: CAM_CTRL_MULTI_EN.
package cam_pkg;

    // Request opcode encodings as seen on req_op_i.
    localparam logic [1:0] OP_SEARCH_ENC = 2'd0;
    localparam logic [1:0] OP_WRITE_ENC  = 2'd1;
    localparam logic [1:0] OP_INVAL_ENC  = 2'd2;
    localparam logic [1:0] OP_FLUSH_ENC  = 2'd3;

    // Controller state encodings.
    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_WRITE_ENC   = 2'd1;
    localparam logic [1:0] ST_COMPARE_ENC = 2'd2;
    localparam logic [1:0] ST_RESP_ENC    = 2'd3;

    typedef enum logic [1:0] {
        OP_SEARCH = OP_SEARCH_ENC,
        OP_WRITE  = OP_WRITE_ENC,
        OP_INVAL  = OP_INVAL_ENC,
        OP_FLUSH  = OP_FLUSH_ENC
    } cam_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_WRITE   = ST_WRITE_ENC,
        ST_COMPARE = ST_COMPARE_ENC,
        ST_RESP    = ST_RESP_ENC
    } cam_state_e;

    // True when n is a power of two and at least 2.
    function automatic bit is_pow2_ge2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Priority encoder for the qualified CAM match vector: lowest index wins.
// rsp multi-hit detection is built only when CAM_CTRL_MULTI_EN is defined.
module cam_prio_enc #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] match,
    output logic             hit,
    output logic [AW-1:0]    index,
    output logic             multi
);

    assign hit = |match;

    // Scan from the top down so the lowest set bit is the last to write index.
    always_comb begin
        // NOTE: default assignment first so no path leaves index unassigned (no latch).
        index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                index = AW'(i);
            end
        end
    end

`ifdef CAM_CTRL_MULTI_EN
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(match & (match - DEPTH'(1)));
`else
    assign multi = 1'b0;
`endif

endmodule

// File: rtl/cam_ctrl.sv
// Sequencing controller for a DEPTH-entry CAM built from WIDTH-bit rows.
// Tracks per-entry valid bits, drives row write/compare, returns one response
// per request. Optional macro: CAM_CTRL_MULTI_EN (enables rsp_multi_o).
module cam_ctrl
    import cam_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [WIDTH-1:0] req_key_i,
    input  logic [AW-1:0]    req_addr_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_hit_o,
    output logic [AW-1:0]    rsp_index_o,
    output logic             rsp_multi_o,
    output logic [DEPTH-1:0] row_we_o,
    output logic [WIDTH-1:0] row_data_o,
    output logic             row_ce_o,
    output logic [WIDTH-1:0] row_compare_o,
    input  logic [DEPTH-1:0] row_match_i
);

    if (!is_pow2_ge2(DEPTH)) begin : g_depth_check
        $error("cam_ctrl: DEPTH must be a power of two >= 2");
    end

    cam_state_e       state;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] match_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] cmp_q;

    // Controller FSM plus valid bits, match capture and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            // NOTE: valid_q is reset because the rows carry no valid state of their own.
            valid_q <= '0;
            match_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cmp_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop sees pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        match_q <= '0;
                        addr_q  <= req_addr_i;
                        case (cam_op_e'(req_op_i))
                            OP_SEARCH: begin
                                cmp_q <= req_key_i;
                                state <= ST_COMPARE;
                            end
                            OP_WRITE: begin
                                data_q <= req_key_i;
                                state  <= ST_WRITE;
                            end
                            OP_INVAL: begin
                                valid_q[req_addr_i] <= 1'b0;
                                state               <= ST_RESP;
                            end
                            OP_FLUSH: begin
                                valid_q <= '0;
                                state   <= ST_RESP;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_WRITE: begin
                    valid_q[addr_q] <= 1'b1;
                    state           <= ST_RESP;
                end
                ST_COMPARE: begin
                    match_q <= row_match_i & valid_q;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        match_q <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake and row strobes decode directly from registered state only.
    assign req_ready_o   = (state == ST_IDLE);
    assign rsp_valid_o   = (state == ST_RESP);
    assign row_we_o      = (state == ST_WRITE) ? (DEPTH'(1) << addr_q) : '0;
    assign row_ce_o      = (state == ST_COMPARE);
    assign row_data_o    = data_q;
    assign row_compare_o = cmp_q;

    cam_prio_enc #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prio_enc (
        .match (match_q),
        .hit   (rsp_hit_o),
        .index (rsp_index_o),
        .multi (rsp_multi_o)
    );

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: directed vector table, reset corner case,
// and randomized traffic against a behavioural CAM model with simulated rows.
module tb_cam_ctrl;
    import cam_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef CAM_CTRL_MULTI_EN
    localparam bit MULTI_EN = 1'b1;
`else
    localparam bit MULTI_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_key;
    logic [AW-1:0]    req_addr;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [AW-1:0]    rsp_index;
    logic             rsp_multi;
    logic [DEPTH-1:0] row_we;
    logic [WIDTH-1:0] row_data;
    logic             row_ce;
    logic [WIDTH-1:0] row_compare;
    logic [DEPTH-1:0] row_match;

    cam_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_key_i     (req_key),
        .req_addr_i    (req_addr),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_hit_o     (rsp_hit),
        .rsp_index_o   (rsp_index),
        .rsp_multi_o   (rsp_multi),
        .row_we_o      (row_we),
        .row_data_o    (row_data),
        .row_ce_o      (row_ce),
        .row_compare_o (row_compare),
        .row_match_i   (row_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simulated row array: stores on its write enable, compares when enabled.
    logic [WIDTH-1:0] rows [DEPTH] = '{default: '0};
    logic             force_en;
    logic [DEPTH-1:0] force_val;

    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (row_we[i]) rows[i] <= row_data;
        end
    end

    always_comb begin
        row_match = '0;
        if (force_en) begin
            row_match = force_val;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                row_match[i] = row_ce && (rows[i] == row_compare);
            end
        end
    end

    // Reference model: what the CAM holds, from the request stream alone.
    logic [WIDTH-1:0] ref_data  [DEPTH] = '{default: '0};
    bit               ref_valid [DEPTH] = '{default: 1'b0};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_search(input logic [WIDTH-1:0] key, output logic hit,
                                         output logic [AW-1:0] idx, output logic multi);
        int cnt = 0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ref_valid[i] && ref_data[i] == key) begin
                if (cnt == 0) idx = AW'(i);
                cnt++;
            end
        end
        hit   = (cnt > 0);
        multi = MULTI_EN && (cnt > 1);
    endfunction

    function automatic void model_apply(input logic [1:0] op, input logic [WIDTH-1:0] key,
                                        input logic [AW-1:0] addr);
        case (op)
            OP_WRITE: begin ref_data[addr] = key; ref_valid[addr] = 1'b1; end
            OP_INVAL: ref_valid[addr] = 1'b0;
            OP_FLUSH: for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
            default: ;
        endcase
    endfunction

    // Issue one request (called at a negedge), check in-flight strobes,
    // latency, response fields, hold stability and back-to-back readiness.
    task automatic do_req(input logic [1:0] op, input logic [WIDTH-1:0] key,
                          input logic [AW-1:0] addr, input logic exp_hit,
                          input logic [AW-1:0] exp_idx, input logic exp_multi,
                          input int hold, input string tag);
        int               lat;
        bit               seen;
        int               exp_lat;
        logic [DEPTH-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        exp_lat  = (op == OP_SEARCH || op == OP_WRITE) ? 2 : 1;
        check($sformatf("%s.req_ready", tag), req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_addr  = addr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_key   = $urandom;
        req_addr  = AW'($urandom);
        model_apply(op, key, addr);
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                lat  = c;
            end else if (c == 1) begin
                check($sformatf("%s.busy_ready", tag), req_ready, 0);
                if (op == OP_WRITE) begin
                    check($sformatf("%s.row_we", tag), row_we, oh);
                    check($sformatf("%s.row_data", tag), row_data, key);
                    check($sformatf("%s.wr_ce", tag), row_ce, 0);
                end else if (op == OP_SEARCH) begin
                    check($sformatf("%s.row_ce", tag), row_ce, 1);
                    check($sformatf("%s.row_compare", tag), row_compare, key);
                    check($sformatf("%s.cmp_we", tag), row_we, 0);
                end
            end
        end
        check($sformatf("%s.latency", tag), lat, exp_lat);
        if (seen) begin
            for (int h = 0; h <= hold; h++) begin
                if (h > 0) @(negedge clk);
                check($sformatf("%s.rsp_valid[%0d]", tag, h), rsp_valid, 1);
                check($sformatf("%s.hit[%0d]", tag, h), rsp_hit, exp_hit);
                check($sformatf("%s.index[%0d]", tag, h), rsp_index, exp_idx);
                check($sformatf("%s.multi[%0d]", tag, h), rsp_multi, exp_multi);
                check($sformatf("%s.rsp_ready_lo[%0d]", tag, h), req_ready, 0);
                check($sformatf("%s.rsp_strobes[%0d]", tag, h), {row_we, row_ce}, 0);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            check($sformatf("%s.post_rsp_valid", tag), rsp_valid, 0);
            check($sformatf("%s.post_req_ready", tag), req_ready, 1);
        end
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] key;
        logic [AW-1:0]    addr;
        logic [DEPTH-1:0] match;
        logic             hit;
        logic [AW-1:0]    idx;
        logic             multi;
        int               hold;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             e_hit;
        logic [AW-1:0]    e_idx;
        logic             e_multi;
        logic [1:0]       op;
        logic [WIDTH-1:0] key;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] pool [4];
        int               r;

        pool = '{32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D, 32'hFFFF_0000};

        vecs.push_back('{OP_SEARCH, 32'hDEADBEEF, 4'd0, 16'hFFFF, 1'b0, 4'd0, 1'b0, 0});
        vecs.push_back('{OP_WRITE,  32'hA5A5A5A5, 4'd5, 16'h0000, 1'b0, 4'd0, 1'b0, 0});
        vecs.push_back('{OP_SEARCH, 32'hA5A5A5A5, 4'd0, 16'h0020, 1'b1, 4'd5, 1'b0, 5});
        vecs.push_back('{OP_WRITE,  32'h11111111, 4'd3, 16'h0000, 1'b0, 4'd0, 1'b0, 0});
        vecs.push_back('{OP_WRITE,  32'h11111111, 4'd9, 16'h0000, 1'b0, 4'd0, 1'b0, 0});
        vecs.push_back('{OP_SEARCH, 32'h11111111, 4'd0, 16'h0208, 1'b1, 4'd3, MULTI_EN, 0});
        vecs.push_back('{OP_INVAL,  32'h0,        4'd3, 16'h0000, 1'b0, 4'd0, 1'b0, 0});
        vecs.push_back('{OP_SEARCH, 32'h11111111, 4'd0, 16'h0208, 1'b1, 4'd9, 1'b0, 0});
        vecs.push_back('{OP_FLUSH,  32'h0,        4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 1});
        vecs.push_back('{OP_SEARCH, 32'h11111111, 4'd0, 16'h0208, 1'b0, 4'd0, 1'b0, 0});
        vecs.push_back('{OP_SEARCH, 32'hA5A5A5A5, 4'd0, 16'hFFFF, 1'b0, 4'd0, 1'b0, 0});

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_key   = '0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        force_en  = 1'b1;
        force_val = '0;
        repeat (2) @(negedge clk);
        check("reset.req_ready", req_ready, 1);
        check("reset.rsp", {rsp_valid, rsp_hit, rsp_index, rsp_multi}, 0);
        check("reset.rows", {row_we, row_ce, row_data, row_compare}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table with forced raw match vectors.
        foreach (vecs[i]) begin
            force_val = vecs[i].match;
            do_req(vecs[i].op, vecs[i].key, vecs[i].addr, vecs[i].hit, vecs[i].idx,
                   vecs[i].multi, vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Reset during COMPARE: async clear, no response, entry gone afterwards.
        force_val = 16'hFFFF;
        do_req(OP_WRITE, 32'h7777_0007, 4'd7, 1'b0, 4'd0, 1'b0, 0, "rst_wr");
        req_valid = 1'b1;
        req_op    = OP_SEARCH;
        req_key   = 32'h7777_0007;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst.in_compare", row_ce, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.async_ready", req_ready, 1);
        check("rst.async_rsp", {rsp_valid, rsp_hit, rsp_index, rsp_multi}, 0);
        check("rst.async_rows", {row_we, row_ce, row_data, row_compare}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst.no_rsp[%0d]", c), rsp_valid, 0);
        end
        do_req(OP_SEARCH, 32'h7777_0007, 4'd0, 1'b0, 4'd0, 1'b0, 0, "rst_search");

        // Randomized traffic; match vectors come from the simulated rows.
        force_en = 1'b0;
        do_req(OP_FLUSH, 32'h0, 4'd0, 1'b0, 4'd0, 1'b0, 0, "rnd_flush");
        for (int t = 0; t < 300; t++) begin
            r    = $urandom_range(0, 9);
            op   = (r < 4) ? OP_SEARCH : (r < 8) ? OP_WRITE : (r == 8) ? OP_INVAL : OP_FLUSH;
            key  = pool[$urandom_range(0, 3)];
            addr = AW'($urandom_range(0, DEPTH - 1));
            e_hit = 1'b0; e_idx = '0; e_multi = 1'b0;
            if (op == OP_SEARCH) model_search(key, e_hit, e_idx, e_multi);
            do_req(op, key, addr, e_hit, e_idx, e_multi, $urandom_range(0, 2),
                   $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_ctrl.md
# cam_ctrl

Sequencing controller for a DEPTH-entry CAM array built from WIDTH-bit `row` instances. It accepts write, invalidate, flush and search requests over a valid/ready handshake. It drives the per-row write enables, write data, compare enable and compare key, and tracks a per-entry valid bit, because rows carry none. It qualifies the raw row match vector with those valid bits, priority-encodes the result, and returns one response per request over a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32, key/data width per row
- DEPTH, 16, number of rows; power of two ≥ 2, checked by an elaboration-time assertion
- AW, $clog2(DEPTH), index width (derived; not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_op_i  in  2  0=SEARCH, 1=WRITE, 2=INVAL, 3=FLUSH
- req_key_i  in  WIDTH  write data (WRITE) or search key (SEARCH)
- req_addr_i  in  AW  target row (WRITE, INVAL)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_hit_o  out  1  SEARCH found at least one valid match; 0 for all other ops
- rsp_index_o  out  AW  lowest matching index; 0 when no hit
- rsp_multi_o  out  1  more than one valid match (see Configuration)
- row_we_o  out  DEPTH  one-hot write enable to the rows
- row_data_o  out  WIDTH  write data broadcast to all rows
- row_ce_o  out  1  compare enable broadcast to all rows
- row_compare_o  out  WIDTH  compare key broadcast to all rows
- row_match_i  in  DEPTH  raw match_o of each row

## Operation
- State machine states: IDLE, WRITE, COMPARE, RESP.
- Request registers: op, key and addr are captured on the accept edge (req_valid_i && req_ready_o). req_ready_o=1 only in IDLE.
- IDLE, on accept:
  - SEARCH → COMPARE
  - WRITE → WRITE
  - INVAL: clear valid[addr] on the accept edge → RESP
  - FLUSH: clear all valid bits on the accept edge → RESP
- WRITE (1 cycle):
  - row_we_o has only bit addr set; row_data_o = captured key.
  - valid[addr] is set on the exiting edge; then → RESP.
  - Overwriting a valid entry is allowed.
- COMPARE (1 cycle):
  - row_ce_o=1; row_compare_o = captured key.
  - On the exiting edge, match_q is loaded with row_match_i & valid; then → RESP.
- RESP:
  - rsp_valid_o=1.
  - hit = |match_q; index = lowest set bit of match_q; multi = popcount(match_q)>1.
  - Outputs are stable until rsp_ready_i; on the handshake edge → IDLE.
- Response fields for non-SEARCH ops: match_q is cleared on accept, so hit, index and multi are all 0.
- Idle values: row_we_o=0, row_ce_o=0; row_data_o and row_compare_o hold their last value (0 after reset).
- Rows never see write and compare in the same cycle.

## Timing
- Reset (async assert, sync-released flops):
  - state=IDLE; valid=0; match_q=0.
  - rsp_valid_o=0, rsp_hit_o=0, rsp_index_o=0, rsp_multi_o=0.
  - row_we_o=0, row_ce_o=0, row_data_o=0, row_compare_o=0.
  - req_ready_o=1 (state is IDLE).
- Reset mid-operation abandons the request with no response. Any write to a row already issued stays in that row but is invalid, because valid is cleared.
- Latency, accept at edge N:
  - SEARCH/WRITE: rsp_valid_o high from cycle N+2.
  - INVAL/FLUSH: rsp_valid_o high from cycle N+1.
- Back-to-back: after the response handshake at edge M, req_ready_o=1 in cycle M+1.
- Best-case throughput: SEARCH/WRITE one per 3 cycles; INVAL/FLUSH one per 2 cycles.
- Write visibility: a WRITE completes before its response, so a following SEARCH always sees the new entry.
- row_match_i is assumed combinationally valid within the COMPARE cycle; it is sampled only at the end of COMPARE.

## Configuration
- CAM_CTRL_MULTI_EN:
  - Defined: rsp_multi_o reports popcount(match_q)>1.
  - Undefined: rsp_multi_o is tied to 0 and the popcount logic is removed. Port list is unchanged.

## Structure
- Package cam_pkg holds:
  - typedef enum cam_op_e (SEARCH, WRITE, INVAL, FLUSH)
  - typedef enum cam_state_e (IDLE, WRITE, COMPARE, RESP)
  - localparam encodings for the above
- Sub-module cam_prio_enc (parameter DEPTH): in match[DEPTH]; out hit, index[AW], multi. Combinational; multi is gated by CAM_CTRL_MULTI_EN.

## Test plan
- Reset, then SEARCH key 0xDEADBEEF with rows returning all-ones match → hit=0, because no entry is valid.
- WRITE addr 5 key 0xA5A5A5A5 → row_we_o=0x0020 for exactly one cycle with row_data_o=0xA5A5A5A5; response hit=0 at N+2. A following SEARCH with row_match_i=0x0020 → hit=1, index=5, multi=0.
- Write rows 3 and 9, then SEARCH with row_match_i=0x0208 → index=3. multi=1 with CAM_CTRL_MULTI_EN defined, multi=0 without.
- INVAL addr 3, then SEARCH with row_match_i=0x0208 → index=9. FLUSH, then the same search → hit=0.
- Hold rsp_ready_i=0 for 5 cycles in RESP → response fields stable and req_ready_o=0 throughout; with rsp_ready_i=1, the next request is accepted one cycle after the handshake.
- Assert rst_n=0 during COMPARE → all outputs reach their reset values asynchronously, no response is issued, and a later SEARCH returns hit=0.
